// File: rtl/uart_rx_core.sv
// 16x-oversampled UART receiver (8N1) with an RX FIFO drained over io_bus.
// Define UART_RX_PARITY_EN to receive 8E1 frames with parity checking.
`timescale 1ns/1ps

module uart_rx_core #(
    parameter int BAUD_DIV   = 54,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        io_bus_s_rd_en,
    input  logic        io_bus_s_wr_en,
    input  logic [31:0] io_bus_s_address,
    input  logic [31:0] io_bus_s_wr_data,
    output logic [31:0] rd_data,
    input  logic        uart_rx,
    output logic        rx_irq
);

    // state    | meaning
    // S_IDLE   | line idle, waiting for a falling edge
    // S_START  | qualifying the start bit at its middle
    // S_DATA   | sampling 8 data bits, LSB first
    // S_PARITY | sampling the even-parity bit (parity build only)
    // S_STOP   | sampling the stop bit, then push or flag

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int DIV_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    logic             sync1_q, sync2_q, rx_prev_q;
    state_t           state_q, state_d;
    logic [DIV_W-1:0] baud_cnt_q, baud_cnt_d;
    logic [3:0]       sample_cnt_q, sample_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             ovr_q, ovr_d, ferr_q, ferr_d, perr_q, perr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      rd_data_q, rd_data_d;
    logic             irq_q, irq_d;
    logic [7:0]       mem_q [FIFO_DEPTH];
`ifdef UART_RX_PARITY_EN
    logic             par_ok_q, par_ok_d;
`endif

    logic        rx, fall, tick, mid_bit;
    logic        push_req, ferr_set, perr_set;
    logic        pop, push, full, ovr_set;
    logic [2:0]  w1c;
    logic [31:0] status_word;
    logic        unused_bits;

    assign rx      = sync2_q;
    assign fall    = rx_prev_q & ~sync2_q;
    assign tick    = (state_q != S_IDLE) && (baud_cnt_q == DIV_W'(BAUD_DIV - 1));
    assign mid_bit = tick && (sample_cnt_q == 4'd15);

    always_comb begin
        state_d      = state_q;
        baud_cnt_d   = (state_q == S_IDLE || tick) ? '0 : baud_cnt_q + DIV_W'(1);
        sample_cnt_d = tick ? sample_cnt_q + 4'd1 : sample_cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        push_req     = 1'b0;
        ferr_set     = 1'b0;
        perr_set     = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_ok_d     = par_ok_q;
`endif
        case (state_q)
            S_IDLE: begin
                sample_cnt_d = '0;
                if (fall) begin
                    state_d    = S_START;
                    baud_cnt_d = '0;
                end
            end
            S_START: begin
                if (tick && sample_cnt_q == 4'd7) begin
                    // A start bit that is high again at its middle was a glitch.
                    if (!rx) begin
                        state_d      = S_DATA;
                        sample_cnt_d = '0;
                        bit_idx_d    = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (mid_bit) begin
                    shift_d   = {rx, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (mid_bit) begin
                    par_ok_d = (rx == ^shift_q);
                    perr_set = (rx != ^shift_q);
                    state_d  = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (mid_bit) begin
                    // Leaving at mid stop bit leaves time to catch the next start edge.
                    state_d = S_IDLE;
                    if (rx) begin
`ifdef UART_RX_PARITY_EN
                        push_req = par_ok_q;
`else
                        push_req = 1'b1;
`endif
                    end else begin
                        ferr_set = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign full    = (count_q == CNT_W'(FIFO_DEPTH));
    assign pop     = io_bus_s_rd_en && (io_bus_s_address[3:2] == 2'd0) && (count_q != '0);
    assign push    = push_req && (!full || pop);
    assign ovr_set = push_req && full && !pop;
    assign w1c     = (io_bus_s_wr_en && io_bus_s_address[3:2] == 2'd1) ? io_bus_s_wr_data[4:2] : 3'b000;

    always_comb begin
        status_word               = '0;
        status_word[0]            = (count_q != '0);
        status_word[1]            = full;
        status_word[2]            = ovr_q;
        status_word[3]            = ferr_q;
        status_word[4]            = perr_q;
        status_word[8 +: CNT_W]   = count_q;
    end

    always_comb begin
        wr_ptr_d  = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d  = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d   = count_q;
        if (push && !pop)
            count_d = count_q + CNT_W'(1);
        else if (pop && !push)
            count_d = count_q - CNT_W'(1);
        // Setting a flag takes priority over clearing it in the same cycle.
        ovr_d     = ovr_set  | (ovr_q  & ~w1c[0]);
        ferr_d    = ferr_set | (ferr_q & ~w1c[1]);
        perr_d    = perr_set | (perr_q & ~w1c[2]);
        irq_d     = (count_q != '0);
        rd_data_d = rd_data_q;
        if (io_bus_s_rd_en) begin
            case (io_bus_s_address[3:2])
                2'd0:    rd_data_d = (count_q != '0) ? {24'b0, mem_q[rd_ptr_q]} : 32'b0;
                2'd1:    rd_data_d = status_word;
                default: rd_data_d = 32'b0;
            endcase
        end
    end

    assign unused_bits = ^{io_bus_s_address[31:4], io_bus_s_address[1:0],
                           io_bus_s_wr_data[31:5], io_bus_s_wr_data[1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            rx_prev_q    <= 1'b1;
            state_q      <= S_IDLE;
            baud_cnt_q   <= '0;
            sample_cnt_q <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            ovr_q        <= 1'b0;
            ferr_q       <= 1'b0;
            perr_q       <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            rd_data_q    <= '0;
            irq_q        <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_ok_q     <= 1'b0;
`endif
        end else begin
            sync1_q      <= uart_rx;
            sync2_q      <= sync1_q;
            rx_prev_q    <= sync2_q;
            state_q      <= state_d;
            baud_cnt_q   <= baud_cnt_d;
            sample_cnt_q <= sample_cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            ovr_q        <= ovr_d;
            ferr_q       <= ferr_d;
            perr_q       <= perr_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            rd_data_q    <= rd_data_d;
            irq_q        <= irq_d;
`ifdef UART_RX_PARITY_EN
            par_ok_q     <= par_ok_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= shift_q;
    end

    assign rd_data = rd_data_q;
    assign rx_irq  = irq_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core; a reduced BAUD_DIV keeps the run short.
`timescale 1ns/1ps

module tb_uart_rx_core;

    localparam int BAUD_DIV = 10;
    localparam int BIT      = 16 * BAUD_DIV;
    localparam int HALF     = BIT / 2;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rd_en = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rd_data;
    logic        uart_rx = 1'b1;
    logic        rx_irq;

    int errors = 0;
    int checks = 0;

    uart_rx_core #(.BAUD_DIV(BAUD_DIV), .FIFO_DEPTH(16)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .io_bus_s_rd_en   (rd_en),
        .io_bus_s_wr_en   (wr_en),
        .io_bus_s_address (addr),
        .io_bus_s_wr_data (wdata),
        .rd_data          (rd_data),
        .uart_rx          (uart_rx),
        .rx_irq           (rx_irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        rd_en = 1'b1;
        addr  = a;
        @(negedge clk);
        rd_en = 1'b0;
        d     = rd_data;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        wr_en = 1'b1;
        addr  = a;
        wdata = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic send_head(input logic [7:0] d, input logic par_v);
        uart_rx = 1'b0;
        wait_clk(BIT);
        for (int i = 0; i < 8; i++) begin
            uart_rx = d[i];
            wait_clk(BIT);
        end
        if (PAR) begin
            uart_rx = par_v;
            wait_clk(BIT);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_v);
        send_head(d, ^d);
        uart_rx = stop_v;
        wait_clk(BIT);
        uart_rx = 1'b1;
    endtask

    logic [31:0] r;

    initial begin
        // reset state
        wait_clk(5);
        chk("reset_rd_data", rd_data, 32'h0);
        chk("reset_irq", {31'b0, rx_irq}, 32'h0);
        rst_n = 1'b1;
        wait_clk(3);
        bus_read(32'h4, r);
        chk("reset_status", r, 32'h0);

        // 1: 0xA5, irq timing around mid stop bit, read and irq drop
        send_head(8'hA5, 1'b0);
        uart_rx = 1'b1;
        wait_clk(HALF - 10);
        chk("t1_irq_early", {31'b0, rx_irq}, 32'h0);
        wait_clk(25);
        chk("t1_irq_set", {31'b0, rx_irq}, 32'h1);
        wait_clk(BIT - HALF);
        bus_read(32'h0, r);
        chk("t1_rxdata", r, 32'h0000_00A5);
        wait_clk(1);
        chk("t1_irq_clear", {31'b0, rx_irq}, 32'h0);
        wait_clk(10);
        chk("t1_rd_hold", rd_data, 32'h0000_00A5);
        bus_read(32'h8, r);
        chk("t1_offset2", r, 32'h0);

        // 2: glitch on the line, then a real frame
        uart_rx = 1'b0;
        wait_clk(BIT / 4);
        uart_rx = 1'b1;
        wait_clk(2 * BIT);
        bus_read(32'h4, r);
        chk("t2_glitch_status", r, 32'h0);
        send_frame(8'h3C, 1'b1);
        wait_clk(20);
        bus_read(32'h0, r);
        chk("t2_rxdata", r, 32'h0000_003C);

        // 3: overflow the FIFO
        for (int i = 0; i < 17; i++)
            send_frame(8'(i), 1'b1);
        wait_clk(20);
        bus_read(32'h4, r);
        chk("t3_status_full", r, 32'h0000_1007);
        for (int i = 0; i < 16; i++) begin
            bus_read(32'h0, r);
            chk($sformatf("t3_rxdata_%0d", i), r, 32'(i));
        end
        bus_read(32'h4, r);
        chk("t3_status_drained", r, 32'h0000_0004);
        bus_write(32'h4, 32'h4);
        bus_read(32'h4, r);
        chk("t3_ovr_cleared", r, 32'h0);

        // 4: framing error and W1C
        send_frame(8'h55, 1'b0);
        wait_clk(20);
        bus_read(32'h4, r);
        chk("t4_ferr", r, 32'h0000_0008);
        bus_write(32'h4, 32'h8);
        bus_read(32'h4, r);
        chk("t4_ferr_cleared", r, 32'h0);

        // 5: empty read, then reset in the middle of a frame
        bus_read(32'h0, r);
        chk("t5_empty_read", r, 32'h0);
        bus_read(32'h4, r);
        chk("t5_empty_count", r, 32'h0);
        send_frame(8'h11, 1'b1);
        wait_clk(20);
        bus_read(32'h4, r);
        chk("t5_one_queued", r, 32'h0000_0101);
        uart_rx = 1'b0;
        wait_clk(BIT);
        uart_rx = 1'b1;
        wait_clk(BIT);
        uart_rx = 1'b0;
        wait_clk(HALF);
        rst_n = 1'b0;
        wait_clk(3);
        uart_rx = 1'b1;
        chk("t5_rst_irq", {31'b0, rx_irq}, 32'h0);
        chk("t5_rst_rd_data", rd_data, 32'h0);
        rst_n = 1'b1;
        wait_clk(2 * BIT);
        bus_read(32'h4, r);
        chk("t5_rst_status", r, 32'h0);
        send_frame(8'hF0, 1'b1);
        wait_clk(20);
        bus_read(32'h0, r);
        chk("t5_rxdata", r, 32'h0000_00F0);

`ifdef UART_RX_PARITY_EN
        // 6: parity error, then correct parity
        send_head(8'h07, 1'b0);
        uart_rx = 1'b1;
        wait_clk(BIT);
        wait_clk(20);
        bus_read(32'h4, r);
        chk("t6_perr", r, 32'h0000_0010);
        bus_write(32'h4, 32'h10);
        send_head(8'h07, 1'b1);
        uart_rx = 1'b1;
        wait_clk(BIT);
        wait_clk(20);
        bus_read(32'h4, r);
        chk("t6_pushed_status", r, 32'h0000_0101);
        bus_read(32'h0, r);
        chk("t6_rxdata", r, 32'h0000_0007);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
